// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit.
// Holds the CSR address map, the csr_op and privilege encodings, the
// mstatus field positions and a helper that says whether an address is
// backed by a register.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    function automatic logic csr_is_impl(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MTVAL, CSR_SATP, CSR_MCYCLE, CSR_MINSTRET, CSR_CYCLE,
            CSR_INSTRET: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/csr_trap_unit_counters.sv
// mcycle / minstret counter pair.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   cycle_we       - load mcycle from wdata instead of incrementing
//   instret_we     - load minstret from wdata instead of incrementing
//   wdata          - value for a committed CSR write
//   retire         - one instruction retired this cycle
//   mcycle         - free-running cycle count
//   minstret       - retired instruction count
// Both counters wrap naturally at 2^XLEN; a load always beats the increment.
module csr_counters
    import csr_trap_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cycle_we,
    input  logic            instret_we,
    input  logic [XLEN-1:0] wdata,
    input  logic            retire,
    output logic [XLEN-1:0] mcycle,
    output logic [XLEN-1:0] minstret
);

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= cycle_we   ? wdata : mcycle + XLEN'(1);
            minstret <= instret_we ? wdata : minstret + XLEN'(retire);
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry and MRET handling.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   valid                 - instruction in the CSR stage is real
//   csr_op/csr_addr       - CSR operation (none/RW/RS/RC) and target
//   csr_wdata             - rs1 value or zero-extended zimm
//   src_is_zero           - rs1 index / zimm is zero (RS/RC then only read)
//   csr_rdata             - pre-update CSR value for rd (combinational)
//   csr_illegal           - access fault (combinational)
//   trap_valid/cause/pc/tval - exception entry request
//   mret                  - MRET retiring
//   retire                - one instruction retired this cycle
//   redirect_valid/pc     - fetch redirect for trap entry or MRET
//   priv, satp, mepc      - registered state for the rest of the core
//   tlb_flush             - one-cycle pulse after a committed satp write
// Priority in a cycle: trap entry, then MRET, then the CSR write.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            src_is_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv,
    output logic [XLEN-1:0] satp,
    output logic [XLEN-1:0] mepc,
    output logic            tlb_flush
);

    // mepc and mtvec hold 4-byte aligned addresses only.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [1:0]      priv_q;
    logic            mie_q;
    logic            mpie_q;
    logic [1:0]      mpp_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] satp_q;
    logic            tlb_flush_q;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] wval;
    logic            wr_intent;
    logic            csr_we;

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE]                   = mie_q;
        mstatus_val[MSTATUS_MPIE]                  = mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:              csr_rdata = mstatus_val;
            CSR_MTVEC:                csr_rdata = mtvec_q;
            CSR_MSCRATCH:             csr_rdata = mscratch_q;
            CSR_MEPC:                 csr_rdata = mepc_q;
            CSR_MCAUSE:               csr_rdata = mcause_q;
            CSR_MTVAL:                csr_rdata = mtval_q;
            CSR_SATP:                 csr_rdata = satp_q;
            CSR_MCYCLE, CSR_CYCLE:    csr_rdata = mcycle;
            CSR_MINSTRET, CSR_INSTRET: csr_rdata = minstret;
            default:                  csr_rdata = '0;
        endcase
    end

    // RS/RC with a zero source are pure reads and must not fault on
    // read-only addresses.
    assign wr_intent = (csr_op == CSR_OP_RW) ||
                       (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && !src_is_zero);

    assign csr_illegal = valid && (csr_op != CSR_OP_NONE) &&
                         (!csr_is_impl(csr_addr) ||
                          (priv_q < csr_addr[9:8]) ||
                          (wr_intent && (csr_addr[11:10] == 2'b11)));

    always_comb begin
        wval = csr_wdata;
        case (csr_op)
            CSR_OP_RS: wval = csr_rdata | csr_wdata;
            CSR_OP_RC: wval = csr_rdata & ~csr_wdata;
            default:   wval = csr_wdata;
        endcase
    end

    assign csr_we = valid && wr_intent && !csr_illegal && !trap_valid && !mret;

    csr_counters #(
        .XLEN(XLEN)
    ) u_counters (
        .clk        (clk),
        .reset      (reset),
        .cycle_we   (csr_we && (csr_addr == CSR_MCYCLE)),
        .instret_we (csr_we && (csr_addr == CSR_MINSTRET)),
        .wdata      (wval),
        .retire     (retire),
        .mcycle     (mcycle),
        .minstret   (minstret)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            priv_q      <= PRIV_M;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mpp_q       <= PRIV_U;
            mtvec_q     <= MTVEC_RESET;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            satp_q      <= '0;
            tlb_flush_q <= 1'b0;
        end else begin
            tlb_flush_q <= csr_we && (csr_addr == CSR_SATP);
            if (trap_valid) begin
                mepc_q   <= trap_pc & ALIGN_MASK;
                mcause_q <= trap_cause;
                mtval_q  <= trap_tval;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
                mpp_q    <= priv_q;
                priv_q   <= PRIV_M;
            end else if (mret) begin
                priv_q <= mpp_q;
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
                mpp_q  <= PRIV_U;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= wval[MSTATUS_MIE];
                        mpie_q <= wval[MSTATUS_MPIE];
                        mpp_q  <= wval[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                    end
                    CSR_MTVEC:    mtvec_q    <= wval & ALIGN_MASK;
                    CSR_MSCRATCH: mscratch_q <= wval;
                    CSR_MEPC:     mepc_q     <= wval & ALIGN_MASK;
                    CSR_MCAUSE:   mcause_q   <= wval;
                    CSR_MTVAL:    mtval_q    <= wval;
                    CSR_SATP:     satp_q     <= wval;
                    default: ;
                endcase
            end
        end
    end

    // Reset masks the redirect even if trap/mret are asserted alongside it.
    assign redirect_valid = !reset && (trap_valid || mret);
    assign redirect_pc    = trap_valid ? mtvec_q : mepc_q;

    assign priv      = priv_q;
    assign satp      = satp_q;
    assign mepc      = mepc_q;
    assign tlb_flush = tlb_flush_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

    localparam int          XLEN   = 64;
    localparam logic [63:0] MTVEC0 = 64'h100;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic        src_is_zero;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        mret;
    logic        retire;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv;
    logic [63:0] satp;
    logic [63:0] mepc;
    logic        tlb_flush;

    int checks   = 0;
    int failures = 0;

    csr_trap_unit #(
        .XLEN(XLEN),
        .MTVEC_RESET(MTVEC0)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .src_is_zero(src_is_zero),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret(mret), .retire(retire),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .priv(priv), .satp(satp), .mepc(mepc), .tlb_flush(tlb_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural CSR state as plain variables.
    logic [1:0]  m_priv, m_mpp;
    logic        m_mie, m_mpie, m_flush;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_satp;
    logic [63:0] m_mcycle, m_minstret;

    logic [63:0] obs_rdata, exp_rdata, obs_rpc, exp_rpc;
    logic [63:0] obs_satp, exp_satp, obs_mepc, exp_mepc;
    logic        obs_ill, exp_ill, obs_rv, exp_rv, obs_flush, exp_flush;
    logic [1:0]  obs_priv, exp_priv;

    logic [11:0] addr_pool [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h180, 12'hB00, 12'hB02, 12'hC00,
                                    12'hC02, 12'h301, 12'h7C0, 12'hFFF};

    function automatic logic m_impl(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
               (a == 12'h342) || (a == 12'h343) || (a == 12'h180) || (a == 12'hB00) ||
               (a == 12'hB02) || (a == 12'hC00) || (a == 12'hC02);
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        logic [63:0] r;
        r = 64'h0;
        if (a == 12'h300) r = {51'b0, m_mpp, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
        else if (a == 12'h305) r = m_mtvec;
        else if (a == 12'h340) r = m_mscratch;
        else if (a == 12'h341) r = m_mepc;
        else if (a == 12'h342) r = m_mcause;
        else if (a == 12'h343) r = m_mtval;
        else if (a == 12'h180) r = m_satp;
        else if (a == 12'hB00 || a == 12'hC00) r = m_mcycle;
        else if (a == 12'hB02 || a == 12'hC02) r = m_minstret;
        return r;
    endfunction

    function automatic logic m_intent();
        return (csr_op == 2'd1) || ((csr_op != 2'd0) && !src_is_zero);
    endfunction

    function automatic logic m_illegal();
        logic [11:0] a;
        a = csr_addr;
        if (!valid || csr_op == 2'd0) return 1'b0;
        return !m_impl(a) || (m_priv < a[9:8]) || (m_intent() && a[11:10] == 2'b11);
    endfunction

    task automatic m_step();
        logic [63:0] old, wv, nc, ni;
        if (reset) begin
            m_priv = 2'd3; m_mie = 0; m_mpie = 0; m_mpp = 0;
            m_mtvec = MTVEC0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_mtval = 0; m_satp = 0; m_mcycle = 0; m_minstret = 0; m_flush = 0;
        end else begin
            old = m_read(csr_addr);
            if (csr_op == 2'd2)      wv = old | csr_wdata;
            else if (csr_op == 2'd3) wv = old & ~csr_wdata;
            else                     wv = csr_wdata;
            nc = m_mcycle + 64'd1;
            ni = m_minstret + (retire ? 64'd1 : 64'd0);
            m_flush = 0;
            if (trap_valid) begin
                m_mepc = {trap_pc[63:2], 2'b00};
                m_mcause = trap_cause;
                m_mtval = trap_tval;
                m_mpie = m_mie;
                m_mie = 0;
                m_mpp = m_priv;
                m_priv = 2'd3;
            end else if (mret) begin
                m_priv = m_mpp;
                m_mie = m_mpie;
                m_mpie = 1;
                m_mpp = 0;
            end else if (valid && m_intent() && !m_illegal()) begin
                case (csr_addr)
                    12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; m_mpp = wv[12:11]; end
                    12'h305: m_mtvec = {wv[63:2], 2'b00};
                    12'h340: m_mscratch = wv;
                    12'h341: m_mepc = {wv[63:2], 2'b00};
                    12'h342: m_mcause = wv;
                    12'h343: m_mtval = wv;
                    12'h180: begin m_satp = wv; m_flush = 1; end
                    12'hB00: nc = wv;
                    12'hB02: ni = wv;
                    default: ;
                endcase
            end
            m_mcycle = nc;
            m_minstret = ni;
        end
    endtask

    // Samples combinational outputs mid-cycle, then registered outputs just
    // after the edge; expectations come from the model at the same points.
    task automatic run_cycle();
        @(negedge clk);
        exp_rdata = m_read(csr_addr);
        exp_ill   = m_illegal();
        exp_rv    = !reset && (trap_valid || mret);
        exp_rpc   = trap_valid ? m_mtvec : m_mepc;
        obs_rdata = csr_rdata;
        obs_ill   = csr_illegal;
        obs_rv    = redirect_valid;
        obs_rpc   = redirect_pc;
        @(posedge clk);
        m_step();
        #1;
        exp_priv = m_priv; exp_satp = m_satp; exp_mepc = m_mepc; exp_flush = m_flush;
        obs_priv = priv;   obs_satp = satp;   obs_mepc = mepc;   obs_flush = tlb_flush;
    endtask

    task automatic clear_in();
        valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; src_is_zero = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        mret = 0; retire = 0;
    endtask

    task automatic set_csr(input logic [1:0] op, input logic [11:0] a,
                           input logic [63:0] wd, input logic sz);
        clear_in();
        valid = 1; csr_op = op; csr_addr = a; csr_wdata = wd; src_is_zero = sz;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        run_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1; trap_valid = 1; mret = 1; trap_pc = 64'h4000;
        valid = 1; csr_op = 2'd1; csr_addr = 12'h180; csr_wdata = 64'h55;
        run_cycle();
        checks++; if (obs_rv !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0b want=0", obs_rv); end
        checks++; if (obs_priv !== 2'd3) begin failures++; $display("FAIL reset_priv got=%0d want=3", obs_priv); end
        checks++; if (obs_satp !== 64'h0 || obs_mepc !== 64'h0) begin failures++; $display("FAIL reset_satp_mepc got=%h/%h want=0/0", obs_satp, obs_mepc); end
        checks++; if (obs_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b want=0", obs_flush); end
        reset = 0;
        set_csr(2'd2, 12'h305, 64'hFF, 1'b1);
        run_cycle();
        checks++; if (obs_rdata !== MTVEC0) begin failures++; $display("FAIL reset_mtvec got=%h want=%h", obs_rdata, MTVEC0); end
        checks++; if (obs_ill !== 1'b0) begin failures++; $display("FAIL reset_read_legal got=%0b want=0", obs_ill); end
        set_csr(2'd2, 12'hB00, 64'h0, 1'b1);
        run_cycle();
        checks++; if (obs_rdata !== 64'd1) begin failures++; $display("FAIL reset_mcycle got=%h want=1", obs_rdata); end
    endtask

    task automatic test_rw_rs();
        do_reset();
        set_csr(2'd1, 12'h340, 64'hDEAD_BEEF, 1'b0);
        run_cycle();
        checks++; if (obs_rdata !== 64'h0) begin failures++; $display("FAIL rw_old got=%h want=0", obs_rdata); end
        set_csr(2'd2, 12'h340, 64'h10, 1'b0);
        run_cycle();
        checks++; if (obs_rdata !== 64'hDEAD_BEEF) begin failures++; $display("FAIL rs_old got=%h want=deadbeef", obs_rdata); end
        set_csr(2'd3, 12'h340, 64'h0, 1'b1);
        run_cycle();
        checks++; if (obs_rdata !== 64'hDEAD_BEFF) begin failures++; $display("FAIL rs_result got=%h want=deadbeff", obs_rdata); end
    endtask

    task automatic test_priv();
        do_reset();
        clear_in(); mret = 1;
        run_cycle();
        checks++; if (obs_priv !== 2'd0) begin failures++; $display("FAIL mret_to_u got=%0d want=0", obs_priv); end
        set_csr(2'd1, 12'h300, 64'h1888, 1'b0);
        run_cycle();
        checks++; if (obs_ill !== 1'b1) begin failures++; $display("FAIL u_mstatus_ill got=%0b want=1", obs_ill); end
        set_csr(2'd2, 12'hC00, 64'h0, 1'b1);
        run_cycle();
        checks++; if (obs_ill !== 1'b0) begin failures++; $display("FAIL u_cycle_ill got=%0b want=0", obs_ill); end
        checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL u_cycle_val got=%h want=%h", obs_rdata, exp_rdata); end
        clear_in(); trap_valid = 1;
        run_cycle();
        set_csr(2'd2, 12'h300, 64'h0, 1'b1);
        run_cycle();
        checks++; if (obs_rdata !== 64'h0) begin failures++; $display("FAIL mstatus_kept got=%h want=0", obs_rdata); end
    endtask

    task automatic test_trap();
        do_reset();
        set_csr(2'd1, 12'h305, 64'h8000_0100, 1'b0); run_cycle();
        set_csr(2'd1, 12'h300, 64'h8, 1'b0); run_cycle();
        clear_in(); trap_valid = 1; trap_pc = 64'h1002; trap_cause = 64'd2; trap_tval = 64'h77;
        run_cycle();
        checks++; if (obs_rv !== 1'b1 || obs_rpc !== 64'h8000_0100) begin failures++; $display("FAIL trap_redirect got=%0b/%h want=1/80000100", obs_rv, obs_rpc); end
        checks++; if (obs_mepc !== 64'h1000) begin failures++; $display("FAIL trap_mepc got=%h want=1000", obs_mepc); end
        checks++; if (obs_priv !== 2'd3) begin failures++; $display("FAIL trap_priv got=%0d want=3", obs_priv); end
        set_csr(2'd2, 12'h342, 64'h0, 1'b1); run_cycle();
        checks++; if (obs_rdata !== 64'd2) begin failures++; $display("FAIL trap_mcause got=%h want=2", obs_rdata); end
        set_csr(2'd2, 12'h300, 64'h0, 1'b1); run_cycle();
        checks++; if (obs_rdata !== 64'h1880) begin failures++; $display("FAIL trap_mstatus got=%h want=1880", obs_rdata); end
        set_csr(2'd2, 12'h343, 64'h0, 1'b1); run_cycle();
        checks++; if (obs_rdata !== 64'h77) begin failures++; $display("FAIL trap_mtval got=%h want=77", obs_rdata); end
        clear_in(); mret = 1; run_cycle();
        checks++; if (obs_rv !== 1'b1 || obs_rpc !== 64'h1000) begin failures++; $display("FAIL mret_redirect got=%0b/%h want=1/1000", obs_rv, obs_rpc); end
    endtask

    task automatic test_priority();
        set_csr(2'd1, 12'h180, 64'hABC, 1'b0);
        trap_valid = 1; mret = 1; trap_pc = 64'h2007; trap_cause = 64'd5;
        run_cycle();
        checks++; if (obs_rpc !== 64'h8000_0100) begin failures++; $display("FAIL prio_redirect got=%h want=80000100", obs_rpc); end
        checks++; if (obs_satp !== 64'h0 || obs_flush !== 1'b0) begin failures++; $display("FAIL prio_satp got=%h/%0b want=0/0", obs_satp, obs_flush); end
        checks++; if (obs_mepc !== 64'h2004 || obs_priv !== 2'd3) begin failures++; $display("FAIL prio_trap got=%h/%0d want=2004/3", obs_mepc, obs_priv); end
    endtask

    task automatic test_satp_flush();
        set_csr(2'd1, 12'h180, 64'h8000_0000_0000_1234, 1'b0);
        run_cycle();
        checks++; if (obs_flush !== 1'b1) begin failures++; $display("FAIL flush_pulse got=%0b want=1", obs_flush); end
        checks++; if (obs_satp !== 64'h8000_0000_0000_1234) begin failures++; $display("FAIL satp_val got=%h want=8000000000001234", obs_satp); end
        clear_in(); run_cycle();
        checks++; if (obs_flush !== 1'b0) begin failures++; $display("FAIL flush_width got=%0b want=0", obs_flush); end
    endtask

    task automatic test_counters();
        set_csr(2'd1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); run_cycle();
        set_csr(2'd2, 12'hB00, 64'h0, 1'b1); run_cycle();
        checks++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mcycle_load got=%h want=all-ones", obs_rdata); end
        run_cycle();
        checks++; if (obs_rdata !== 64'h0) begin failures++; $display("FAIL mcycle_wrap got=%h want=0", obs_rdata); end
        set_csr(2'd1, 12'hB02, 64'h55, 1'b0); retire = 1; run_cycle();
        set_csr(2'd2, 12'hB02, 64'h0, 1'b1); retire = 1; run_cycle();
        checks++; if (obs_rdata !== 64'h55) begin failures++; $display("FAIL minstret_win got=%h want=55", obs_rdata); end
        retire = 0; run_cycle();
        checks++; if (obs_rdata !== 64'h56) begin failures++; $display("FAIL minstret_inc got=%h want=56", obs_rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clear_in();
            reset       = ($urandom_range(0, 149) == 0);
            valid       = ($urandom_range(0, 3) != 0);
            csr_op      = 2'($urandom_range(0, 3));
            csr_addr    = addr_pool[$urandom_range(0, 13)];
            csr_wdata   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            src_is_zero = ($urandom_range(0, 3) == 0);
            trap_valid  = ($urandom_range(0, 11) == 0);
            trap_cause  = 64'($urandom);
            trap_pc     = {$urandom, $urandom};
            trap_tval   = {$urandom, $urandom};
            mret        = ($urandom_range(0, 11) == 0);
            retire      = $urandom_range(0, 1) == 1;
            run_cycle();
            checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h want=%h", i, csr_addr, obs_rdata, exp_rdata); end
            if (!reset) begin
                checks++; if (obs_ill !== exp_ill) begin failures++; $display("FAIL rnd_illegal i=%0d got=%0b want=%0b", i, obs_ill, exp_ill); end
            end
            checks++; if (obs_rv !== exp_rv) begin failures++; $display("FAIL rnd_rvalid i=%0d got=%0b want=%0b", i, obs_rv, exp_rv); end
            if (exp_rv) begin
                checks++; if (obs_rpc !== exp_rpc) begin failures++; $display("FAIL rnd_rpc i=%0d got=%h want=%h", i, obs_rpc, exp_rpc); end
            end
            checks++; if (obs_priv !== exp_priv) begin failures++; $display("FAIL rnd_priv i=%0d got=%0d want=%0d", i, obs_priv, exp_priv); end
            checks++; if (obs_satp !== exp_satp) begin failures++; $display("FAIL rnd_satp i=%0d got=%h want=%h", i, obs_satp, exp_satp); end
            checks++; if (obs_mepc !== exp_mepc) begin failures++; $display("FAIL rnd_mepc i=%0d got=%h want=%h", i, obs_mepc, exp_mepc); end
            checks++; if (obs_flush !== exp_flush) begin failures++; $display("FAIL rnd_flush i=%0d got=%0b want=%0b", i, obs_flush, exp_flush); end
        end
        reset = 0;
    endtask

    task automatic test_readback();
        clear_in(); trap_valid = 1; run_cycle();
        for (int k = 0; k < 14; k++) begin
            set_csr(2'd2, addr_pool[k], 64'h0, 1'b1);
            run_cycle();
            checks++; if (obs_rdata !== exp_rdata) begin failures++; $display("FAIL readback addr=%h got=%h want=%h", addr_pool[k], obs_rdata, exp_rdata); end
            checks++; if (obs_ill !== exp_ill) begin failures++; $display("FAIL readback_ill addr=%h got=%0b want=%0b", addr_pool[k], obs_ill, exp_ill); end
        end
    endtask

    initial begin
        clear_in();
        reset = 1;
        test_reset();
        test_rw_rs();
        test_priv();
        test_trap();
        test_priority();
        test_satp_flush();
        test_counters();
        test_random();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, 64, register and datapath width.
REQ-002 SHALL have parameter MTVEC_RESET, 0, reset value of mtvec.
REQ-003 SHALL have port clk, input, 1, clock, rising edge; reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port valid, input, 1, instruction in stage is real (not a bubble).
REQ-005 SHALL have port csr_op, input, 2, operation: 0 none, 1 RW, 2 RS, 3 RC.
REQ-006 SHALL have port csr_addr, input, 12, target CSR.
REQ-007 SHALL have port csr_wdata, input, XLEN, rs1 value or zero-extended zimm.
REQ-008 SHALL have port src_is_zero, input, 1, rs1 index or zimm is 0.
REQ-009 SHALL have port csr_rdata, output, XLEN, old CSR value for rd.
REQ-010 SHALL have port csr_illegal, output, 1, access faults.
REQ-011 SHALL have ports trap_valid (1), trap_cause (XLEN), trap_pc (XLEN) and trap_tval (XLEN), inputs, exception request.
REQ-012 SHALL have port mret, input, 1, MRET retiring.
REQ-013 SHALL have port retire, input, 1, one instruction retired this cycle.
REQ-014 SHALL have ports redirect_valid (1) and redirect_pc (XLEN), outputs, fetch redirect.
REQ-015 SHALL have ports priv (2), satp (XLEN), mepc (XLEN) and tlb_flush (1), outputs.

Function
REQ-016 Implemented CSRs SHALL be: mstatus 0x300 (only MIE[3], MPIE[7], MPP[12:11] writable, all other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, satp 0x180, mcycle 0xB00, minstret 0xB02, cycle 0xC00 (read-only alias), instret 0xC02 (read-only alias).
REQ-017 csr_rdata SHALL be combinational, reflecting pre-update values; any unimplemented address SHALL read 0.
REQ-018 Write intent SHALL be: RW always; RS/RC only when !src_is_zero.
REQ-019 csr_illegal SHALL assert combinationally when valid and csr_op!=0 and any of: address unimplemented; priv < csr_addr[9:8]; write intent with csr_addr[11:10]==2'b11.
REQ-020 Write value SHALL be: RW wdata; RS old|wdata; RC old&~wdata. The register SHALL update at the next edge only if valid, write intent, and !csr_illegal.
REQ-021 Writes to mepc SHALL clear bits [1:0]; writes to mtvec SHALL clear bits [1:0] (direct mode only).
REQ-022 mcycle SHALL increment by 1 every cycle and minstret SHALL increment when retire is high, both wrapping at 2^XLEN; a same-cycle CSR write SHALL win over the increment.
REQ-023 Trap entry (trap_valid) SHALL update at the next edge: mepc<=trap_pc with bits [1:0] cleared, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=3.
REQ-024 On trap entry, redirect_valid SHALL be 1 and redirect_pc SHALL be the mtvec value, combinationally in the trap cycle.
REQ-025 MRET SHALL update at the next edge: priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=0. In that cycle redirect_pc SHALL be the mepc value and redirect_valid SHALL be 1.
REQ-026 Priority SHALL be: trap_valid > mret > CSR write. A lower-priority action SHALL be suppressed entirely in that cycle; counters still advance.
REQ-027 tlb_flush SHALL pulse high for exactly one cycle, the cycle after a committed satp write; a satp write that is suppressed or illegal SHALL not pulse it.
REQ-028 Outputs satp and mepc SHALL reflect the registered values.

Reset
REQ-029 On reset: priv=3; mtvec=MTVEC_RESET; mcycle, minstret and all other CSRs=0; tlb_flush=0; redirect_valid=0. Reset SHALL override trap, mret and write inputs in the same cycle.

Structure
REQ-030 A shared package SHALL hold the CSR address constants, the csr_op and privilege enums, and the mstatus bit positions.
REQ-031 The counter pair SHALL be one sub-module, csr_counters, with write-override and increment inputs.

Verification
REQ-032 Reset, then RW 0x340 with 0xDEAD_BEEF, then RS with 0x10 -> second op returns 0xDEAD_BEEF; mscratch reads 0xDEAD_BEFF.
REQ-033 Set priv=0 via mret with MPP=0, then RW 0x300 -> csr_illegal=1 and mstatus unchanged; RS 0xC00 with src_is_zero=1 -> legal and returns cycle count.
REQ-034 mtvec=0x8000_0100, MIE=1, trap_valid with pc 0x1002 and cause 2 -> redirect_pc=0x8000_0100; mepc=0x1000; mcause=2; MIE=0; MPIE=1; priv=3.
REQ-035 trap_valid and mret and a satp RW in the same cycle -> only the trap takes effect; satp unchanged; tlb_flush stays 0.
REQ-036 RW satp 0x8000_0000_0000_1234 -> tlb_flush high exactly one cycle later, for one cycle.
REQ-037 RW mcycle 0xFFFF_FFFF_FFFF_FFFF -> mcycle wraps to 0 after one more cycle; RW minstret with retire=1 -> written value kept.
